ring_rr_arbiter: RTL

RING_RR_ARBITER -- requirements
Module: ring_rr_arbiter

---
 rtl/ring_arb_pkg.sv | 15 +
 rtl/ring_rr_pick.sv | 36 +++
 rtl/ring_rr_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/ring_arb_pkg.sv
// Shared definitions for the ring-pointer round-robin arbiter family.
//   arb_state_t  : arbiter FSM state encoding (IDLE=0, BUSY=1)
//   DEF_N        : default number of requesters
//   DEF_MAX_HOLD : default maximum consecutive grant cycles per tenure
package ring_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational ring-pointer pick: returns the first set bit of req scanning
// upward from the one-hot token position, wrapping N-1 to 0.
// Ports:
//   req    [N-1:0] in  : request vector, bit i = requester i
//   token  [N-1:0] in  : one-hot pointer, highest-priority position
//   winner [N-1:0] out : one-hot winner, zero when req is zero
//   any            out : high when any request is present
module ring_rr_pick
  import ring_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] token,
  output logic [N-1:0] winner,
  output logic         any
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] upper;

  // Requests at or above the token win first; otherwise wrap to the lowest
  // set request. x & (~x + 1) isolates the lowest set bit of x.
  always_comb begin
    upper  = req & ~(token - ONE);
    winner = '0;
    if (|upper) begin
      winner = upper & (~upper + ONE);
    end else begin
      winner = req & (~req + ONE);
    end
    any = |req;
  end

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot token and bounded tenure.
// A granted requester keeps the grant while it requests, for at most
// MAX_HOLD consecutive cycles. On release or expiry the token moves just past
// the owner and the next winner is granted in the same cycle (no bubble).
// Ports:
//   clk                  in  : clock, rising edge
//   rstn                 in  : synchronous active-low reset
//   req        [N-1:0]   in  : request levels
//   grant      [N-1:0]   out : registered one-hot grant, zero when idle
//   grant_valid          out : high when grant is non-zero
//   grant_id   [IW-1:0]  out : binary index of the granted requester, 0 idle
//   token      [N-1:0]   out : one-hot ring pointer for the next arbitration
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id,
  output logic [N-1:0]  token
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t   state;
  logic [HW-1:0] hold_cnt;

  logic         end_tenure;
  logic [N-1:0] token_nxt;
  logic [N-1:0] winner;
  logic         any;

  function automatic logic [IW-1:0] onehot_to_bin(input logic [N-1:0] oh);
    logic [IW-1:0] b;
    b = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) b = b | IW'(i);
    end
    return b;
  endfunction

  // The tenure ends when the owner drops its request or uses its last cycle.
  // The token then points just past the owner, so the owner is scanned last
  // and can only be re-granted when nobody else is requesting.
  always_comb begin
    end_tenure = (state == BUSY) && (((grant & req) == '0) || (hold_cnt == HOLD_LAST));
    token_nxt  = token;
    if (end_tenure) begin
      token_nxt = {grant[N-2:0], grant[N-1]};
    end
  end

  ring_rr_pick #(
    .N(N)
  ) u_pick (
    .req    (req),
    .token  (token_nxt),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      hold_cnt    <= '0;
      token       <= N'(1);
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state       <= BUSY;
            grant       <= winner;
            grant_valid <= 1'b1;
            grant_id    <= onehot_to_bin(winner);
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          if (end_tenure) begin
            token <= token_nxt;
            if (any) begin
              grant       <= winner;
              grant_valid <= 1'b1;
              grant_id    <= onehot_to_bin(winner);
              hold_cnt    <= '0;
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_id    <= '0;
              hold_cnt    <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
